pipeline_ctrl: RTL and testbench

Central stall/flush controller for the five-stage CPU pipeline. It collects hazard and wait requests from ID (load-use, taken branch), EXE (multi-cycle ALU ops) and MEM (memory/IO handshake), and drives per-register hold and bubble controls for the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers. It owns the multi-cycle EXE sequencer and the MEM wait timeout.

---
 rtl/pipeline_ctrl_pkg.sv | 34 +++
 rtl/pipeline_ctrl_mc_sequencer.sv | 86 ++++++++
 rtl/pipeline_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared types and constants for the pipeline stall/flush controller:
//   - mc_state_e  : EXE multi-cycle sequencer states (IDLE/BUSY/DONE)
//   - stall_src_e : stall source index, equal to the deepest register held
//   - ZERO_WORD / NOP_REG_ADDR : common zero constants
//   - sat_inc32() : saturating 32-bit increment used by the perf counters
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

    // Index of the deepest pipeline register a source must hold
    // (PC = 0, IF/ID = 1, ID/EXE = 2, EXE/MEM = 3, MEM/WB = 4).
    typedef enum logic [1:0] {
        SRC_NONE     = 2'd0,
        SRC_LOAD_USE = 2'd1,
        SRC_EXE_BUSY = 2'd2,
        SRC_MEM_WAIT = 2'd3
    } stall_src_e;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR = 5'd0;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        sat_inc32 = (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_mc_sequencer.sv
// -----------------------------------------------------------------------------
// mc_sequencer
// Tracks a multi-cycle operation occupying EXE. A start seen in IDLE loads the
// down-counter with MC_CYCLES-2; the op is reported busy for MC_CYCLES-1 cycles
// (the start cycle plus every BUSY cycle with a non-zero count). The cnt == 0
// cycle moves to DONE without holding, and DONE retires the result as soon as
// MEM is not waiting.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start_i        level: a multi-cycle op sits in EXE (ignored outside IDLE)
//   mem_wait_i     MEM stage is stalling; keeps the result parked in DONE
//   busy_o         EXE must be held this cycle
//   done_o         multi-cycle result is valid and advances this cycle
// -----------------------------------------------------------------------------
module mc_sequencer
    import pipeline_ctrl_pkg::*;
#(
    parameter int MC_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic mem_wait_i,
    output logic busy_o,
    output logic done_o
);

    localparam int CW = (MC_CYCLES > 2) ? $clog2(MC_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MC_CYCLES - 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    mc_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State and down-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and busy/done decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            MC_IDLE: begin
                if (start_i) begin
                    state_d = MC_BUSY;
                    cnt_d   = CNT_INIT;
                    busy_o  = 1'b1;
                end else begin
                    state_d = MC_IDLE;
                end
            end
            MC_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d  = cnt_q - CNT_ONE;
                    busy_o = 1'b1;
                end else begin
                    // Last cycle in EXE: no hold, result parks in DONE.
                    state_d = MC_DONE;
                end
            end
            MC_DONE: begin
                if (!mem_wait_i) begin
                    state_d = MC_IDLE;
                    done_o  = 1'b1;
                end else begin
                    state_d = MC_DONE;
                end
            end
            default: begin
                state_d = MC_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush controller for the five-stage pipeline. Stall sources
// are ranked by the deepest register they must hold (load-use = 1, EXE busy = 2,
// MEM wait = 3); the deepest active source k holds PC..register k and bubbles
// register k+1. A taken branch in ID flushes IF/ID only when IF/ID is not held.
// All hold/bubble/done/timeout outputs are combinational and forced to 0 while
// rst is high.
// Optional feature macro: PIPE_PERF_CNT_EN enables the saturating stall and
// flush counters; without it both perf outputs are constant zero.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   id_rs_addr/id_rt_addr/_used     ID source registers and their use flags
//   id_branch_taken                 branch/jump resolved taken in ID
//   exe_is_load, exe_write_reg      load in EXE and its destination
//   exe_mc_start                    multi-cycle op in EXE (level)
//   mem_req, mem_ack                MEM handshake request / completion
//   *_hold, *_bubble                per-register hold and NOP-load controls
//   exe_mc_done                     multi-cycle result advances this cycle
//   mem_timeout                     pulse on forced MEM release
//   perf_stall_cycles/flush_count   performance counters
// -----------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MC_CYCLES   = 8,
    parameter int MEM_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic        id_branch_taken,
    input  logic        exe_is_load,
    input  logic [4:0]  exe_write_reg,
    input  logic        exe_mc_start,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_hold,
    output logic        if_id_hold,
    output logic        id_exe_hold,
    output logic        exe_mem_hold,
    output logic        if_id_bubble,
    output logic        id_exe_bubble,
    output logic        exe_mem_bubble,
    output logic        mem_wb_bubble,
    output logic        exe_mc_done,
    output logic        mem_timeout,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
);

    localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [15:0] WAIT_LAST  = TIMEOUT_EN ? 16'(MEM_TIMEOUT - 1) : 16'd0;

    logic        load_use_s;
    logic        exe_busy_s;
    logic        seq_done_s;
    logic        timeout_hit_s;
    logic        mem_wait_s;
    stall_src_e  src_s;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    // Hazard detection and MEM wait qualification.
    always_comb begin
        load_use_s    = exe_is_load && (exe_write_reg != NOP_REG_ADDR) &&
                        ((id_rs_used && (id_rs_addr == exe_write_reg)) ||
                         (id_rt_used && (id_rt_addr == exe_write_reg)));
        timeout_hit_s = TIMEOUT_EN && (wait_cnt_q == WAIT_LAST);
        mem_wait_s    = mem_req && !mem_ack && !timeout_hit_s;
    end

    mc_sequencer #(
        .MC_CYCLES (MC_CYCLES)
    ) u_mc_sequencer (
        .clk        (clk),
        .rst        (rst),
        .start_i    (exe_mc_start),
        .mem_wait_i (mem_wait_s),
        .busy_o     (exe_busy_s),
        .done_o     (seq_done_s)
    );

    // Deepest active source wins; shallower ones are re-seen after release.
    always_comb begin
        if (mem_wait_s) begin
            src_s = SRC_MEM_WAIT;
        end else if (exe_busy_s) begin
            src_s = SRC_EXE_BUSY;
        end else if (load_use_s) begin
            src_s = SRC_LOAD_USE;
        end else begin
            src_s = SRC_NONE;
        end
    end

    // Hold/bubble/pulse decode, all forced low during reset.
    always_comb begin
        pc_hold        = 1'b0;
        if_id_hold     = 1'b0;
        id_exe_hold    = 1'b0;
        exe_mem_hold   = 1'b0;
        if_id_bubble   = 1'b0;
        id_exe_bubble  = 1'b0;
        exe_mem_bubble = 1'b0;
        mem_wb_bubble  = 1'b0;
        exe_mc_done    = 1'b0;
        mem_timeout    = 1'b0;
        if (!rst) begin
            case (src_s)
                SRC_LOAD_USE: begin
                    pc_hold       = 1'b1;
                    if_id_hold    = 1'b1;
                    id_exe_bubble = 1'b1;
                end
                SRC_EXE_BUSY: begin
                    pc_hold        = 1'b1;
                    if_id_hold     = 1'b1;
                    id_exe_hold    = 1'b1;
                    exe_mem_bubble = 1'b1;
                end
                SRC_MEM_WAIT: begin
                    pc_hold       = 1'b1;
                    if_id_hold    = 1'b1;
                    id_exe_hold   = 1'b1;
                    exe_mem_hold  = 1'b1;
                    mem_wb_bubble = 1'b1;
                end
                default: begin
                    // IF/ID is free to move, so a taken branch flushes it now.
                    if_id_bubble = id_branch_taken;
                end
            endcase
            exe_mc_done = seq_done_s;
            mem_timeout = mem_req && !mem_ack && timeout_hit_s;
        end else begin
            exe_mc_done = 1'b0;
            mem_timeout = 1'b0;
        end
    end

    // MEM wait length: counts consecutive wait cycles, saturating.
    always_comb begin
        if (mem_wait_s) begin
            wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : (wait_cnt_q + 16'd1);
        end else begin
            wait_cnt_d = 16'd0;
        end
    end

    // MEM wait counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= 16'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    // Saturating stall-cycle and branch-flush counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= ZERO_WORD;
            perf_flush_q <= ZERO_WORD;
        end else begin
            perf_stall_q <= pc_hold      ? sat_inc32(perf_stall_q) : perf_stall_q;
            perf_flush_q <= if_id_bubble ? sat_inc32(perf_flush_q) : perf_flush_q;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_count  = perf_flush_q;
`else
    assign perf_stall_cycles = ZERO_WORD;
    assign perf_flush_count  = ZERO_WORD;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Two controllers share all inputs: DUT A with MEM_TIMEOUT=4, DUT B with
// MEM_TIMEOUT=0 (no timeout). A reference model tracks the multi-cycle op by
// its age in EXE and the MEM wait by its run length, and predicts every output.
// Directed steps cover the listed scenarios with literal expectations, then a
// randomized run is checked against the model.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam int MC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs_addr, id_rt_addr, exe_write_reg;
    logic        id_rs_used, id_rt_used, id_branch_taken;
    logic        exe_is_load, exe_mc_start, mem_req, mem_ack;

    logic a_pc_h, a_ifid_h, a_idexe_h, a_exemem_h;
    logic a_ifid_b, a_idexe_b, a_exemem_b, a_memwb_b, a_done, a_tmo;
    logic b_pc_h, b_ifid_h, b_idexe_h, b_exemem_h;
    logic b_ifid_b, b_idexe_b, b_exemem_b, b_memwb_b, b_done, b_tmo;
    logic [31:0] a_stall, a_flush, b_stall, b_flush;
    logic [9:0]  a_vec, b_vec;

    int vectors = 0;
    int miscompares = 0;

    // Model state: [0] -> DUT A, [1] -> DUT B
    bit         m_active[2], n_active[2];
    int         m_age[2], n_age[2];
    int         m_wait[2], n_wait[2];
    int         m_stall[2], n_stall[2];
    int         m_flush[2], n_flush[2];
    logic [9:0] exp_vec[2];

    always #5 clk = ~clk;

    pipeline_ctrl #(.MC_CYCLES(MC), .MEM_TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_branch_taken(id_branch_taken),
        .exe_is_load(exe_is_load), .exe_write_reg(exe_write_reg),
        .exe_mc_start(exe_mc_start), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_hold(a_pc_h), .if_id_hold(a_ifid_h), .id_exe_hold(a_idexe_h),
        .exe_mem_hold(a_exemem_h), .if_id_bubble(a_ifid_b),
        .id_exe_bubble(a_idexe_b), .exe_mem_bubble(a_exemem_b),
        .mem_wb_bubble(a_memwb_b), .exe_mc_done(a_done), .mem_timeout(a_tmo),
        .perf_stall_cycles(a_stall), .perf_flush_count(a_flush)
    );

    pipeline_ctrl #(.MC_CYCLES(MC), .MEM_TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_branch_taken(id_branch_taken),
        .exe_is_load(exe_is_load), .exe_write_reg(exe_write_reg),
        .exe_mc_start(exe_mc_start), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_hold(b_pc_h), .if_id_hold(b_ifid_h), .id_exe_hold(b_idexe_h),
        .exe_mem_hold(b_exemem_h), .if_id_bubble(b_ifid_b),
        .id_exe_bubble(b_idexe_b), .exe_mem_bubble(b_exemem_b),
        .mem_wb_bubble(b_memwb_b), .exe_mc_done(b_done), .mem_timeout(b_tmo),
        .perf_stall_cycles(b_stall), .perf_flush_count(b_flush)
    );

    // {pc_h, ifid_h, idexe_h, exemem_h, ifid_b, idexe_b, exemem_b, memwb_b, done, timeout}
    assign a_vec = {a_pc_h, a_ifid_h, a_idexe_h, a_exemem_h,
                    a_ifid_b, a_idexe_b, a_exemem_b, a_memwb_b, a_done, a_tmo};
    assign b_vec = {b_pc_h, b_ifid_h, b_idexe_h, b_exemem_h,
                    b_ifid_b, b_idexe_b, b_exemem_b, b_memwb_b, b_done, b_tmo};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: predicts outputs for the current cycle and the next state.
    task automatic model_eval(input int d, input int t);
        bit lu, hit, mw, tmo, starting, act, busy, done, flush;
        int age, depth;
        logic [4:0] hold, bub;
        lu = exe_is_load && (exe_write_reg != 5'd0) &&
             ((id_rs_used && (id_rs_addr == exe_write_reg)) ||
              (id_rt_used && (id_rt_addr == exe_write_reg)));
        hit      = (t != 0) && (m_wait[d] == t - 1);
        mw       = mem_req && !mem_ack && !hit;
        tmo      = mem_req && !mem_ack && hit;
        starting = !m_active[d] && exe_mc_start;
        act      = m_active[d] || starting;
        age      = starting ? 1 : m_age[d];
        busy     = act && (age <= MC - 1);
        done     = m_active[d] && (age > MC) && !mw;
        depth    = mw ? 3 : (busy ? 2 : (lu ? 1 : 0));
        for (int r = 0; r < 5; r++) begin
            hold[r] = (depth > 0) && (r <= depth);
            bub[r]  = (depth > 0) && (r == depth + 1);
        end
        flush = id_branch_taken && (depth == 0);
        if (rst) begin
            exp_vec[d] = 10'd0;
            n_active[d] = 1'b0; n_age[d] = 0; n_wait[d] = 0;
            n_stall[d] = 0; n_flush[d] = 0;
        end else begin
            exp_vec[d] = {hold[0], hold[1], hold[2], hold[3],
                          bub[1] | flush, bub[2], bub[3], bub[4], done, tmo};
            n_wait[d] = mw ? m_wait[d] + 1 : 0;
            if (done) begin
                n_active[d] = 1'b0; n_age[d] = 0;
            end else if (act) begin
                n_active[d] = 1'b1; n_age[d] = age + 1;
            end else begin
                n_active[d] = 1'b0; n_age[d] = 0;
            end
            n_stall[d] = m_stall[d] + ((depth > 0) ? 1 : 0);
            n_flush[d] = m_flush[d] + (flush ? 1 : 0);
        end
    endtask

    task automatic sample();
        logic [31:0] es0, es1, ef0, ef1;
        @(negedge clk);
        model_eval(0, 4);
        model_eval(1, 0);
`ifdef PIPE_PERF_CNT_EN
        es0 = m_stall[0]; es1 = m_stall[1]; ef0 = m_flush[0]; ef1 = m_flush[1];
`else
        es0 = 32'd0; es1 = 32'd0; ef0 = 32'd0; ef1 = 32'd0;
`endif
        check("a_ctl", {22'd0, a_vec}, {22'd0, exp_vec[0]});
        check("b_ctl", {22'd0, b_vec}, {22'd0, exp_vec[1]});
        check("a_stall", a_stall, es0);
        check("a_flush", a_flush, ef0);
        check("b_stall", b_stall, es1);
        check("b_flush", b_flush, ef1);
    endtask

    task automatic advance();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            m_active[d] = n_active[d]; m_age[d] = n_age[d]; m_wait[d] = n_wait[d];
            m_stall[d] = n_stall[d]; m_flush[d] = n_flush[d];
        end
        #1;
    endtask

    task automatic step_lit(input string tag, input logic [9:0] ea, input logic [9:0] eb);
        sample();
        check({tag, "_a"}, {22'd0, a_vec}, {22'd0, ea});
        check({tag, "_b"}, {22'd0, b_vec}, {22'd0, eb});
        advance();
    endtask

    task automatic clear_inputs();
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; exe_write_reg = 5'd0;
        id_rs_used = 1'b0; id_rt_used = 1'b0; id_branch_taken = 1'b0;
        exe_is_load = 1'b0; exe_mc_start = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    localparam logic [9:0] V_ZERO = 10'b0000000000;
    localparam logic [9:0] V_LU   = 10'b1100010000;
    localparam logic [9:0] V_EXE  = 10'b1110001000;
    localparam logic [9:0] V_MEM  = 10'b1111000100;
    localparam logic [9:0] V_FL   = 10'b0000100000;
    localparam logic [9:0] V_DONE = 10'b0000000010;
    localparam logic [9:0] V_TMO  = 10'b0000000001;

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_active[d] = 1'b0; m_age[d] = 0; m_wait[d] = 0;
            m_stall[d] = 0; m_flush[d] = 0;
        end
        clear_inputs();
        rst = 1'b1;
        step_lit("reset0", V_ZERO, V_ZERO);
        step_lit("reset1", V_ZERO, V_ZERO);
        rst = 1'b0;
        step_lit("idle", V_ZERO, V_ZERO);

        // Load r5 in EXE, ID reads r5: one stall cycle.
        exe_is_load = 1'b1; exe_write_reg = 5'd5; id_rs_addr = 5'd5; id_rs_used = 1'b1;
        step_lit("lu", V_LU, V_LU);
        exe_is_load = 1'b0;
        step_lit("lu_rel", V_ZERO, V_ZERO);
        // Destination r0 never creates a hazard.
        exe_is_load = 1'b1; exe_write_reg = 5'd0; id_rs_addr = 5'd0;
        step_lit("lu_r0", V_ZERO, V_ZERO);
        clear_inputs();

        // Taken branch: flush now, or after a concurrent load-use releases.
        id_branch_taken = 1'b1;
        step_lit("flush", V_FL, V_FL);
        exe_is_load = 1'b1; exe_write_reg = 5'd7; id_rt_addr = 5'd7; id_rt_used = 1'b1;
        step_lit("br_lu", V_LU, V_LU);
        exe_is_load = 1'b0;
        step_lit("br_rel", V_FL, V_FL);
        clear_inputs();

        // Multi-cycle op with start held high throughout.
        exe_mc_start = 1'b1;
        for (int i = 0; i < MC - 1; i++) step_lit("mc_hold", V_EXE, V_EXE);
        step_lit("mc_gap", V_ZERO, V_ZERO);
        step_lit("mc_done", V_DONE, V_DONE);
        exe_mc_start = 1'b0;
        step_lit("mc_idle", V_ZERO, V_ZERO);

        // Multi-cycle op finishing into a 3-cycle MEM wait.
        exe_mc_start = 1'b1;
        step_lit("mcw_hold", V_EXE, V_EXE);
        exe_mc_start = 1'b0;
        for (int i = 0; i < MC - 2; i++) step_lit("mcw_hold", V_EXE, V_EXE);
        step_lit("mcw_gap", V_ZERO, V_ZERO);
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) step_lit("mcw_wait", V_MEM, V_MEM);
        mem_ack = 1'b1;
        step_lit("mcw_ack", V_DONE, V_DONE);
        clear_inputs();
        step_lit("mcw_idle", V_ZERO, V_ZERO);

        // Never-acked MEM request: A releases on the 4th cycle, B keeps holding.
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) step_lit("tmo_wait", V_MEM, V_MEM);
        step_lit("tmo_hit", V_TMO, V_MEM);
        step_lit("tmo_rearm", V_MEM, V_MEM);
        mem_req = 1'b0;
        step_lit("tmo_idle", V_ZERO, V_ZERO);

        // Reset while BUSY with cnt = 3.
        exe_mc_start = 1'b1;
        step_lit("rb_hold", V_EXE, V_EXE);
        exe_mc_start = 1'b0;
        for (int i = 0; i < 3; i++) step_lit("rb_hold", V_EXE, V_EXE);
        rst = 1'b1;
        step_lit("rb_rst", V_ZERO, V_ZERO);
        rst = 1'b0;
        sample();
        check("rb_after", {22'd0, a_vec}, 32'd0);
        check("rb_perf_stall", a_stall, 32'd0);
        check("rb_perf_flush", a_flush, 32'd0);
        advance();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst             = ($urandom_range(0, 199) == 0);
            id_rs_addr      = 5'($urandom_range(0, 3));
            id_rt_addr      = 5'($urandom_range(0, 3));
            exe_write_reg   = 5'($urandom_range(0, 3));
            id_rs_used      = $urandom_range(0, 1) == 1;
            id_rt_used      = $urandom_range(0, 1) == 1;
            exe_is_load     = $urandom_range(0, 2) == 0;
            id_branch_taken = $urandom_range(0, 3) == 0;
            exe_mc_start    = $urandom_range(0, 5) == 0;
            if ($urandom_range(0, 5) == 0) mem_req = !mem_req;
            mem_ack         = mem_req && ($urandom_range(0, 5) == 0);
            sample();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
